// File: rtl/pulse_meter_pkg.sv
// pulse_meter_pkg: shared FSM state encoding and default counter width for pulse_meter.
package pulse_meter_pkg;

   // Measurement FSM states; encodings are fixed so other tools can decode them.
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_RISE = 2'd1,
      MEAS_HIGH = 2'd2,
      MEAS_LOW  = 2'd3
   } meter_state_t;

   // Default width of the high/low phase counters.
   localparam int CNT_W_DEFAULT = 8;

endpackage

// File: rtl/pulse_meter_edge_detect.sv
// edge_detect: registers the measured stream into s and flags a rising edge of s.
// Configuration macro PULSE_METER_SYNC_EN adds a 2-flop synchronizer ahead of s
// for asynchronous sources; otherwise din is registered once.
module edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic s,
   output logic rise
);

   logic s_d;
   logic din_q;

`ifdef PULSE_METER_SYNC_EN
   logic sync_1;
   logic sync_2;

   // Two synchronizer stages; the history clears on reset like the rest of the pipe.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
      end else begin
         sync_1 <= din;
         sync_2 <= sync_1;
      end
   end

   assign din_q = sync_2;
`else
   assign din_q = din;
`endif

   // Sample the stream and keep one cycle of history for edge detection.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s   <= 1'b0;
         s_d <= 1'b0;
      end else begin
         s   <= din_q;
         s_d <= s;
      end
   end

   assign rise = s & ~s_d;

endmodule

// File: rtl/pulse_meter.sv
// pulse_meter: measures high and low phase lengths of a 1-bit stream, one result
// per rise..rise period, delivered over a valid/ready handshake.
// Configuration macro PULSE_METER_SYNC_EN (handled in edge_detect) adds input
// synchronization; counts are unaffected, only latency grows.
module pulse_meter
   import pulse_meter_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             din,
   input  logic             meas_ready,
   output logic             meas_valid,
   output logic [CNT_W-1:0] high_len,
   output logic [CNT_W-1:0] low_len,
   output logic             meas_sat,
   output logic             overrun
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   meter_state_t     state;
   meter_state_t     state_next;
   logic [CNT_W-1:0] hcnt;
   logic [CNT_W-1:0] hcnt_next;
   logic [CNT_W-1:0] lcnt;
   logic [CNT_W-1:0] lcnt_next;
   logic             sat_flag;
   logic             sat_flag_next;
   logic             complete;
   logic             s;
   logic             rise;

   edge_detect u_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (din),
      .s     (s),
      .rise  (rise)
   );

   // FSM state and phase counters; reset discards any partial period.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         hcnt     <= '0;
         lcnt     <= '0;
         sat_flag <= 1'b0;
      end else begin
         state    <= state_next;
         hcnt     <= hcnt_next;
         lcnt     <= lcnt_next;
         sat_flag <= sat_flag_next;
      end
   end

   // Next-state and counter updates; a rise while measuring low closes the period
   // and immediately starts the next one so back-to-back periods leave no gap.
   always_comb begin
      state_next    = state;
      hcnt_next     = hcnt;
      lcnt_next     = lcnt;
      sat_flag_next = sat_flag;
      complete      = 1'b0;
      if (!en) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: begin
               state_next = WAIT_RISE;
            end
            WAIT_RISE: begin
               if (rise) begin
                  state_next    = MEAS_HIGH;
                  hcnt_next     = CNT_ONE;
                  lcnt_next     = '0;
                  sat_flag_next = 1'b0;
               end
            end
            MEAS_HIGH: begin
               if (s) begin
                  if (hcnt == CNT_MAX) begin
                     sat_flag_next = 1'b1;
                  end else begin
                     hcnt_next = hcnt + CNT_ONE;
                  end
               end else begin
                  state_next = MEAS_LOW;
                  lcnt_next  = CNT_ONE;
               end
            end
            MEAS_LOW: begin
               if (rise) begin
                  complete      = 1'b1;
                  state_next    = MEAS_HIGH;
                  hcnt_next     = CNT_ONE;
                  lcnt_next     = '0;
                  sat_flag_next = 1'b0;
               end else if (!s) begin
                  if (lcnt == CNT_MAX) begin
                     sat_flag_next = 1'b1;
                  end else begin
                     lcnt_next = lcnt + CNT_ONE;
                  end
               end
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   // Result registers and handshake; a completion that finds an unaccepted result
   // is dropped and recorded in the sticky overrun flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meas_valid <= 1'b0;
         high_len   <= '0;
         low_len    <= '0;
         meas_sat   <= 1'b0;
         overrun    <= 1'b0;
      end else if (complete) begin
         if (!meas_valid || meas_ready) begin
            meas_valid <= 1'b1;
            high_len   <= hcnt;
            low_len    <= lcnt;
            meas_sat   <= sat_flag;
         end else begin
            overrun <= 1'b1;
         end
      end else if (meas_valid && meas_ready) begin
         meas_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pulse_meter.sv
// tb_pulse_meter: drives two pulse_meter instances (CNT_W=8 and CNT_W=4) from the
// same stimulus and checks them every cycle against a period-level reference model.
module tb_pulse_meter;

`ifdef PULSE_METER_SYNC_EN
   localparam int SYNC = 2;
`else
   localparam int SYNC = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       din = 1'b0;
   logic       meas_ready = 1'b0;

   logic       valid8, sat8, ovr8;
   logic [7:0] h8, l8;
   logic       valid4, sat4, ovr4;
   logic [3:0] h4, l4;

   pulse_meter #(.CNT_W(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .en(en), .din(din), .meas_ready(meas_ready),
      .meas_valid(valid8), .high_len(h8), .low_len(l8), .meas_sat(sat8), .overrun(ovr8)
   );

   pulse_meter #(.CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .en(en), .din(din), .meas_ready(meas_ready),
      .meas_valid(valid4), .high_len(h4), .low_len(l4), .meas_sat(sat4), .overrun(ovr4)
   );

   always #5 clk = ~clk;

   int  n_checks = 0;
   int  n_fail = 0;
   bit  check_en = 1'b0;

   // Reference model: unbounded high/low sample counts per period, clamped on output.
   int  m_mode = 0;
   int  m_h = 0;
   int  m_l = 0;
   bit  hist [0:4];
   bit  m_s, m_sd, m_pub;
   int  pub_h, pub_l;
   bit  e_valid = 1'b0;
   bit  e_ovr = 1'b0;
   int  e_h = 0;
   int  e_l = 0;

   // Bench-side driving state and observation of delivered results.
   bit  cur_en = 1'b0;
   bit  cur_ready = 1'b0;
   bit  rand_ready = 1'b0;
   int  vcount = 0;
   int  last_h8, last_l8, last_sat8, last_h4, last_l4, last_sat4;

   function automatic int clampv(input int v, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   function automatic int satv(input int h, input int l, input int w);
      int mx;
      mx = (1 << w) - 1;
      return ((h > mx) || (l > mx)) ? 1 : 0;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model advance: periods are measured on din delayed by the register pipeline.
   always @(posedge clk) begin
      m_pub = 1'b0;
      if (!rst_n) begin
         m_mode = 0;
         m_h = 0;
         m_l = 0;
         for (int i = 0; i < 5; i++) hist[i] = 1'b0;
         e_valid = 1'b0;
         e_ovr = 1'b0;
         e_h = 0;
         e_l = 0;
      end else begin
         m_s  = hist[SYNC];
         m_sd = hist[SYNC + 1];
         if (!en) begin
            m_mode = 0;
         end else if (m_mode == 0) begin
            m_mode = 1;
         end else if (m_mode == 1) begin
            if (m_s && !m_sd) begin
               m_mode = 2;
               m_h = 1;
               m_l = 0;
            end
         end else begin
            if (m_s) begin
               if (m_l > 0) begin
                  m_pub = 1'b1;
                  pub_h = m_h;
                  pub_l = m_l;
                  m_h = 1;
                  m_l = 0;
               end else begin
                  m_h++;
               end
            end else begin
               m_l++;
            end
         end
         if (m_pub) begin
            if (!e_valid || meas_ready) begin
               e_valid = 1'b1;
               e_h = pub_h;
               e_l = pub_l;
            end else begin
               e_ovr = 1'b1;
            end
         end else if (e_valid && meas_ready) begin
            e_valid = 1'b0;
         end
         for (int i = 4; i > 0; i--) hist[i] = hist[i - 1];
         hist[0] = din;
      end
   end

   task automatic checkOutput();
      check("valid8", valid8, e_valid);
      check("valid4", valid4, e_valid);
      check("overrun8", ovr8, e_ovr);
      check("overrun4", ovr4, e_ovr);
      if (e_valid) begin
         check("high_len8", h8, clampv(e_h, 8));
         check("low_len8", l8, clampv(e_l, 8));
         check("meas_sat8", sat8, satv(e_h, e_l, 8));
         check("high_len4", h4, clampv(e_h, 4));
         check("low_len4", l4, clampv(e_l, 4));
         check("meas_sat4", sat4, satv(e_h, e_l, 4));
      end
   endtask

   // Every-cycle comparison away from the active edge.
   always @(negedge clk) begin
      if (check_en) checkOutput();
   end

   // One cycle of stimulus; also records delivered results for the literal checks.
   task automatic applyStimulus(input bit d, input bit e, input bit r, input bit rn);
      din = d;
      en = e;
      meas_ready = r;
      rst_n = rn;
      @(negedge clk);
      if (valid8 === 1'b1) begin
         vcount++;
         last_h8 = h8;
         last_l8 = l8;
         last_sat8 = sat8;
         last_h4 = h4;
         last_l4 = l4;
         last_sat4 = sat4;
      end
   endtask

   task automatic runDin(input bit d, input int n);
      for (int i = 0; i < n; i++) begin
         if (rand_ready) cur_ready = ($urandom_range(0, 2) != 0);
         applyStimulus(d, cur_en, cur_ready, 1'b1);
      end
   endtask

   task automatic doReset();
      applyStimulus(1'b0, cur_en, cur_ready, 1'b0);
   endtask

   initial begin
      // Reset with enable high and din toggling: everything stays zero.
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      check_en = 1'b1;
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      check("rst_valid", valid8, 0);
      check("rst_overrun", ovr8, 0);
      check("rst_high", h8, 0);
      check("rst_low", l8, 0);
      check("rst_sat", sat8, 0);

      // Steady 3 high / 5 low periods with the consumer always ready.
      cur_en = 1'b1;
      cur_ready = 1'b1;
      runDin(1'b0, 3);
      vcount = 0;
      for (int p = 0; p < 6; p++) begin
         runDin(1'b1, 3);
         runDin(1'b0, 5);
      end
      runDin(1'b0, 4);
      check("steady_count", vcount, 5);
      check("steady_high", last_h8, 3);
      check("steady_low", last_l8, 5);
      check("steady_sat", last_sat8, 0);

      // Saturation: 20 high, 2 low, then a terminating rise.
      cur_en = 1'b0;
      runDin(1'b0, 3);
      cur_en = 1'b1;
      runDin(1'b0, 3);
      vcount = 0;
      runDin(1'b1, 20);
      runDin(1'b0, 2);
      runDin(1'b1, 1);
      runDin(1'b0, 4);
      check("sat_count", vcount, 1);
      check("sat_high4", last_h4, 15);
      check("sat_low4", last_l4, 2);
      check("sat_flag4", last_sat4, 1);
      check("sat_high8", last_h8, 20);
      check("sat_flag8", last_sat8, 0);

      // Back-pressure across several 2/2 periods, then acceptance.
      doReset();
      cur_en = 1'b1;
      cur_ready = 1'b0;
      runDin(1'b0, 3);
      for (int p = 0; p < 3; p++) begin
         runDin(1'b1, 2);
         runDin(1'b0, 2);
      end
      runDin(1'b1, 1);
      runDin(1'b0, 3);
      check("bp_valid", valid8, 1);
      check("bp_overrun", ovr8, 1);
      check("bp_high", h8, 2);
      check("bp_low", l8, 2);
      cur_ready = 1'b1;
      runDin(1'b0, 1);
      check("bp_accept_valid", valid8, 0);
      check("bp_overrun_sticky", ovr8, 1);

      // Reset while a result is held and overrun is set.
      cur_ready = 1'b0;
      runDin(1'b1, 2);
      runDin(1'b0, 2);
      runDin(1'b1, 1);
      runDin(1'b0, 3);
      check("mid_valid", valid8, 1);
      check("mid_overrun", ovr8, 1);
      doReset();
      check("mid_rst_valid", valid8, 0);
      check("mid_rst_overrun", ovr8, 0);
      check("mid_rst_high", h8, 0);

      // Abort mid-low, then a fresh rise..rise is needed for the next result.
      cur_en = 1'b1;
      cur_ready = 1'b1;
      runDin(1'b0, 3);
      vcount = 0;
      runDin(1'b1, 2);
      runDin(1'b0, 1);
      cur_en = 1'b0;
      runDin(1'b0, 2);
      cur_en = 1'b1;
      runDin(1'b0, 2);
      runDin(1'b1, 2);
      runDin(1'b0, 2);
      runDin(1'b1, 1);
      runDin(1'b0, 3);
      check("abort_count", vcount, 1);
      check("abort_high", last_h8, 2);
      check("abort_low", last_l8, 2);

      // Randomized runs with random back-pressure, enable drops and rare resets.
      rand_ready = 1'b1;
      for (int k = 0; k < 400; k++) begin
         cur_en = ($urandom_range(0, 15) != 0);
         if ($urandom_range(0, 79) == 0) doReset();
         runDin(k[0], $urandom_range(1, 20));
      end
      rand_ready = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
